// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle: channel a/b inputs, mux select, registered output stage.
// master drives the channels and y_ready; slave is the arbiter side.
interface mux2_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             sel;
  logic             y_valid;
  logic [WIDTH-1:0] y_data;
  logic             y_src;
  logic             y_ready;

  modport master (
    output a_valid, a_data, b_valid, b_data, y_ready,
    input  a_ready, b_ready, sel, y_valid, y_data, y_src
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, y_ready,
    output a_ready, b_ready, sel, y_valid, y_data, y_src
  );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Round-robin 2:1 valid/ready arbiter with burst allowance feeding a one-entry output register.
// Latency 1 cycle accept-to-y_valid; a_ready/b_ready drop while the output register is stalled.
module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 1,
  parameter int PRIO_INIT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  mux2_rr_arbiter_if.slave  bus
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  localparam owner_e OWN_RST = (PRIO_INIT != 0) ? OWN_B : OWN_A;

  owner_e           owner;
  logic [CW-1:0]    cnt;
  logic             y_valid_q;
  logic [WIDTH-1:0] y_data_q;
  logic             y_src_q;

  logic load_en;
  logic grant;
  logic accept;
  logic from_owner;

  // Owner only matters when both channels contend; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (bus.a_valid && bus.b_valid) begin
      grant = (owner == OWN_B);
    end else if (bus.b_valid) begin
      grant = 1'b1;
    end
  end

  assign load_en    = !y_valid_q || bus.y_ready;
  assign accept     = load_en && (grant ? bus.b_valid : bus.a_valid);
  assign from_owner = (grant == (owner == OWN_B));

  assign bus.sel     = grant;
  assign bus.a_ready = load_en && !grant;
  assign bus.b_ready = load_en && grant;
  assign bus.y_valid = y_valid_q;
  assign bus.y_data  = y_data_q;
  assign bus.y_src   = y_src_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_src_q   <= 1'b0;
    end else if (accept) begin
      y_valid_q <= 1'b1;
      y_data_q  <= grant ? bus.b_data : bus.a_data;
      y_src_q   <= grant;
    end else if (bus.y_ready) begin
      y_valid_q <= 1'b0;
    end
  end

  // Non-owner transfers use idle slots and never consume the owner's burst allowance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= OWN_RST;
      cnt   <= '0;
    end else if (accept && from_owner) begin
      if (cnt == CNT_LAST) begin
        owner <= (owner == OWN_A) ? OWN_B : OWN_A;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
